// File: rtl/risc_mem_arbiter.sv
// risc_mem_arbiter: two-requester (CPU / debug loader) arbiter for a single-port synchronous memory.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise the CPU has fixed priority.
module risc_mem_arbiter #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic              cpu_wr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic [AWIDTH-1:0] dbg_addr,
    input  logic              dbg_wr,
    input  logic [DWIDTH-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DWIDTH-1:0] rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic              pick_dbg;
`ifdef ARB_ROUND_ROBIN_EN
    assign pick_dbg = dbg_req & (~cpu_req | ~owner_q);
`else
    assign pick_dbg = dbg_req & ~cpu_req;
`endif
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        cpu_ack_d = 1'b0;
        dbg_ack_d = 1'b0;
        case (state_q)
            IDLE: if (cpu_req | dbg_req) begin
                state_d  = ACCESS;
                owner_d  = pick_dbg;
                wr_d     = pick_dbg ? dbg_wr : cpu_wr;
                addr_d   = pick_dbg ? dbg_addr : cpu_addr;
                wdata_d  = pick_dbg ? dbg_wdata : cpu_wdata;
                mem_wr_d = wr_d;
                mem_rd_d = ~wr_d;
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d   = IDLE;
                rdata_d   = wr_q ? rdata_q : mem_rdata;
                cpu_ack_d = ~owner_q;
                dbg_ack_d = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            cpu_ack_q <= cpu_ack_d;
            dbg_ack_q <= dbg_ack_d;
        end
    end
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign rdata     = rdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = state_q != IDLE;
    assign owner     = owner_q;
endmodule

// File: tb/tb_risc_mem_arbiter.sv
// tb_risc_mem_arbiter: directed checks of risc_mem_arbiter against a behavioural single-port memory.
module tb_risc_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_req = 1'b0, cpu_wr = 1'b0, dbg_req = 1'b0, dbg_wr = 1'b0;
    logic [4:0] cpu_addr = '0, dbg_addr = '0;
    logic [7:0] cpu_wdata = '0, dbg_wdata = '0;
    logic       cpu_ack, dbg_ack, mem_rd, mem_wr, busy, owner;
    logic [7:0] rdata, mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic [4:0] mem_addr;
    logic [7:0] mem [32];
    logic       init_q = 1'b0;
    int         passed = 0, total = 0;

    always #5 clk = ~clk;

    risc_mem_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wr(dbg_wr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
        .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    // Memory preloads mem[i] = i*0x11, except mem[31] = 0x3C.
    always @(posedge clk) begin
        if (!init_q) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 31) ? 8'h3C : 8'(i * 8'h11);
            init_q <= 1'b1;
        end else begin
            if (mem_wr) mem[mem_addr] <= mem_wdata;
            if (mem_rd) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic test_reset;
        #12;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if ({mem_rd, mem_wr} !== 2'b00) $display("FAIL reset_strobes got %b want 00", {mem_rd, mem_wr}); else passed++;
        total++; if ({cpu_ack, dbg_ack} !== 2'b00) $display("FAIL reset_acks got %b want 00", {cpu_ack, dbg_ack}); else passed++;
        total++; if (rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", rdata); else passed++;
        total++; if (owner !== 1'b1) $display("FAIL reset_owner got %b want 1", owner); else passed++;
        total++; if ({mem_addr, mem_wdata} !== 13'h0) $display("FAIL reset_latch got %h/%h want 00/00", mem_addr, mem_wdata); else passed++;
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_cpu_write;
        cpu_req = 1'b1; cpu_addr = 5'h03; cpu_wr = 1'b1; cpu_wdata = 8'hA5;
        @(negedge clk);
        total++; if ({mem_wr, mem_rd} !== 2'b10) $display("FAIL cw_strobes got %b want 10", {mem_wr, mem_rd}); else passed++;
        total++; if (mem_addr !== 5'h03) $display("FAIL cw_addr got %h want 03", mem_addr); else passed++;
        total++; if (mem_wdata !== 8'hA5) $display("FAIL cw_wdata got %h want a5", mem_wdata); else passed++;
        total++; if ({busy, owner} !== 2'b10) $display("FAIL cw_busy_owner got %b want 10", {busy, owner}); else passed++;
        @(negedge clk);
        total++; if ({mem_wr, busy, cpu_ack} !== 3'b010) $display("FAIL cw_resp got %b want 010", {mem_wr, busy, cpu_ack}); else passed++;
        @(negedge clk);
        total++; if ({cpu_ack, dbg_ack, busy} !== 3'b100) $display("FAIL cw_ack got %b want 100", {cpu_ack, dbg_ack, busy}); else passed++;
        total++; if (rdata !== 8'h00) $display("FAIL cw_rdata got %h want 00", rdata); else passed++;
        total++; if (mem[3] !== 8'hA5) $display("FAIL cw_mem got %h want a5", mem[3]); else passed++;
        cpu_req = 1'b0;
        @(negedge clk);
        total++; if ({cpu_ack, busy, mem_wr} !== 3'b000) $display("FAIL cw_after got %b want 000", {cpu_ack, busy, mem_wr}); else passed++;
    endtask

    task automatic test_dbg_read;
        dbg_req = 1'b1; dbg_addr = 5'h1F; dbg_wr = 1'b0; dbg_wdata = 8'h00;
        @(negedge clk);
        total++; if ({mem_rd, mem_wr} !== 2'b10) $display("FAIL dr_strobes got %b want 10", {mem_rd, mem_wr}); else passed++;
        total++; if (mem_addr !== 5'h1F) $display("FAIL dr_addr got %h want 1f", mem_addr); else passed++;
        total++; if (owner !== 1'b1) $display("FAIL dr_owner got %b want 1", owner); else passed++;
        @(negedge clk);
        total++; if (mem_rd !== 1'b0) $display("FAIL dr_rd_once got %b want 0", mem_rd); else passed++;
        @(negedge clk);
        total++; if ({dbg_ack, cpu_ack} !== 2'b10) $display("FAIL dr_ack got %b want 10", {dbg_ack, cpu_ack}); else passed++;
        total++; if (rdata !== 8'h3C) $display("FAIL dr_rdata got %h want 3c", rdata); else passed++;
        dbg_req = 1'b0;
        @(negedge clk);
        total++; if ({dbg_ack, rdata} !== {1'b0, 8'h3C}) $display("FAIL dr_after got %b/%h want 0/3c", dbg_ack, rdata); else passed++;
    endtask

    task automatic test_simultaneous;
        logic [3:0] order = '0;
        int         n = 0, n_dbg = 0, overlap = 0;
`ifdef ARB_ROUND_ROBIN_EN
        logic [3:0] exp_order = 4'b1010;
        int         exp_dbg = 2;
`else
        logic [3:0] exp_order = 4'b0000;
        int         exp_dbg = 0;
`endif
        cpu_req = 1'b1; cpu_addr = 5'h02; cpu_wr = 1'b0;
        dbg_req = 1'b1; dbg_addr = 5'h04; dbg_wr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((mem_rd & mem_wr) | (cpu_ack & dbg_ack)) overlap++;
            if (cpu_ack | dbg_ack) begin
                if (n < 4) order[n] = dbg_ack;
                n++;
                if (dbg_ack) n_dbg++;
                total++;
                if (rdata !== (dbg_ack ? 8'h44 : 8'h22)) $display("FAIL sim_rdata got %h want %h", rdata, dbg_ack ? 8'h44 : 8'h22);
                else passed++;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        total++; if (n !== 4) $display("FAIL sim_count got %0d want 4", n); else passed++;
        total++; if (order !== exp_order) $display("FAIL sim_order got %b want %b", order, exp_order); else passed++;
        total++; if (n_dbg !== exp_dbg) $display("FAIL sim_dbg_acks got %0d want %0d", n_dbg, exp_dbg); else passed++;
        total++; if (overlap !== 0) $display("FAIL sim_overlap got %0d want 0", overlap); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL sim_idle got %b want 0", busy); else passed++;
    endtask

    task automatic test_reset_abort;
        int acks = 0, wrs = 0;
        cpu_req = 1'b1; cpu_addr = 5'h07; cpu_wr = 1'b1; cpu_wdata = 8'h5A;
        @(negedge clk);
        total++; if (mem_wr !== 1'b1) $display("FAIL ra_access got %b want 1", mem_wr); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if ({busy, mem_wr} !== 2'b00) $display("FAIL ra_async got %b want 00", {busy, mem_wr}); else passed++;
        total++; if (owner !== 1'b1) $display("FAIL ra_owner got %b want 1", owner); else passed++;
        cpu_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpu_ack) acks++;
            if (mem_wr) wrs++;
        end
        total++; if ({acks, wrs} !== {32'd0, 32'd0}) $display("FAIL ra_no_ack got acks=%0d wrs=%0d want 0/0", acks, wrs); else passed++;
        total++; if (mem[7] !== 8'h77) $display("FAIL ra_mem got %h want 77", mem[7]); else passed++;
    endtask

    task automatic test_drop_while_busy;
        int c_acks = 0, d_acks = 0, wrs = 0;
        dbg_req = 1'b1; dbg_addr = 5'h1F; dbg_wr = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 5'h09; cpu_wr = 1'b1; cpu_wdata = 8'hFF;
        @(negedge clk);
        cpu_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpu_ack) c_acks++;
            if (mem_wr) wrs++;
            if (dbg_ack) begin d_acks++; dbg_req = 1'b0; end
        end
        total++; if (c_acks !== 0) $display("FAIL dwb_cpu_ack got %0d want 0", c_acks); else passed++;
        total++; if (wrs !== 0) $display("FAIL dwb_mem_wr got %0d want 0", wrs); else passed++;
        total++; if (d_acks !== 1) $display("FAIL dwb_dbg_ack got %0d want 1", d_acks); else passed++;
        total++; if (mem[9] !== 8'h99) $display("FAIL dwb_mem got %h want 99", mem[9]); else passed++;
        total++; if (rdata !== 8'h3C) $display("FAIL dwb_rdata got %h want 3c", rdata); else passed++;
    endtask

    initial begin
        test_reset;
        test_cpu_write;
        test_dbg_read;
        test_simultaneous;
        test_reset_abort;
        test_drop_while_busy;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/risc_mem_arbiter.md
RISC_MEM_ARBITER -- requirements
Module: risc_mem_arbiter

Interface
REQ-001 Parameter AWIDTH, 5: memory address width.
REQ-002 Parameter DWIDTH, 8: memory data width.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-low.
REQ-005 Port cpu_req  input  1: CPU access request; cpu_addr, cpu_wr and cpu_wdata are held stable while high.
REQ-006 Port cpu_addr  input  AWIDTH: CPU access address.
REQ-007 Port cpu_wr  input  1: CPU access type (1 = write, 0 = read).
REQ-008 Port cpu_wdata  input  DWIDTH: CPU write data.
REQ-009 Port cpu_ack  output  1: one-cycle pulse marking completion of a CPU access.
REQ-010 Port dbg_req, dbg_addr, dbg_wr, dbg_wdata  input  1/AWIDTH/1/DWIDTH: debug-loader request set, same rules as the CPU set.
REQ-011 Port dbg_ack  output  1: one-cycle pulse marking completion of a debug access.
REQ-012 Port rdata  output  DWIDTH: read data; valid in the cycle of the matching ack for a read.
REQ-013 Port mem_rd, mem_wr  output  1: strobes to the single-port synchronous memory.
REQ-014 Port mem_addr  output  AWIDTH: memory address.
REQ-015 Port mem_wdata  output  DWIDTH: memory write data.
REQ-016 Port mem_rdata  input  DWIDTH: memory read data; valid the cycle after mem_rd.
REQ-017 Port busy  output  1: high in any state other than IDLE.
REQ-018 Port owner  output  1: current or last grant holder (0 = CPU, 1 = debug).

Function
REQ-019 The FSM SHALL have three states, IDLE, ACCESS and RESP, each held for one cycle except IDLE.
REQ-020 In IDLE with at least one req high, the block SHALL select a winner, latch its addr, wr and wdata, set owner, and go to ACCESS.
REQ-021 In IDLE with no req high, the block SHALL stay in IDLE with all memory strobes low.
REQ-022 In ACCESS, the block SHALL drive mem_addr and mem_wdata from the latched values, with mem_wr = latched wr and mem_rd = the inverse of latched wr, for exactly one cycle, then go to RESP.
REQ-023 In RESP, the block SHALL register mem_rdata into rdata on a read, leave rdata unchanged on a write, pulse the owner's ack high for one cycle, and return to IDLE.
REQ-024 Latency SHALL be 3 cycles from the req sample in IDLE to the ack; peak throughput SHALL be one access per 3 cycles.
REQ-025 The block SHALL never assert mem_rd and mem_wr together, and never both acks together.
REQ-026 After a grant, requester inputs SHALL be ignored until the block returns to IDLE; a req dropped before the grant SHALL produce no access.
REQ-027 A req still high in the IDLE that follows its ack SHALL be treated as a new request.
REQ-028 Strobe and ack outputs SHALL be registered (no combinational path from req to mem_*).

Reset
REQ-029 While rst = 0, the block SHALL asynchronously force IDLE, with all strobes, acks and busy at 0, rdata = 0, owner = 1, and the latched addr/wdata at 0.
REQ-030 Reset asserted during ACCESS or RESP SHALL abort the access; no ack SHALL follow the release of reset.

Configuration
REQ-031 With macro ARB_ROUND_ROBIN_EN defined, when both reqs are high in IDLE, the block SHALL grant the requester that is not the current owner; with the reset owner = 1, the CPU wins first.
REQ-032 Without ARB_ROUND_ROBIN_EN, the block SHALL use fixed priority: the CPU always wins a tie.

Verification
REQ-033 CPU write: cpu_req = 1, addr 5'h03, wdata 8'hA5, wr = 1 -> mem_wr high for one cycle at addr 3 with data A5; cpu_ack 3 cycles after the request; rdata unchanged.
REQ-034 Debug read: mem[5'h1F] = 8'h3C, dbg_req read at addr 1F -> mem_rd for one cycle; dbg_ack with rdata = 8'h3C; owner = 1.
REQ-035 Simultaneous reqs held for 4 accesses -> with the macro, grant order CPU, DBG, CPU, DBG; without it, CPU four times and no dbg_ack.
REQ-036 rst pulsed low during ACCESS of a CPU write -> busy = 0, mem_wr = 0 immediately; no cpu_ack after release; the memory location is unchanged if reset preceded the clock edge.
REQ-037 cpu_req pulsed for one cycle, dropping while busy on a debug access -> no CPU access and no cpu_ack.
